// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - state encoding shared by counter_ctrl and its bench
package counter_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_PAUSE = S_PAUSE,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/counter_core.sv
// rtl/counter_core.sv - WIDTH-bit up-counter datapath with clear-over-enable priority
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/pause/abort sequencer for counter_core with terminal-count tick
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             tick_q, tick_d;
  logic             cnt_en, cnt_clr;
  logic             at_limit;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .count(count)
  );

  assign at_limit = (count == limit_q);

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_RUN;
            cnt_clr    = 1'b1;
            limit_d    = limit;
            periodic_d = periodic;
          end
        end
        ST_RUN: begin
          // start outranks pause even though it is a no-op while running
          if (pause && !start) begin
            state_d = ST_PAUSE;
          end else if (at_limit) begin
            tick_d = 1'b1;
            if (periodic_q) cnt_clr = 1'b1;
            else            state_d = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed self-checking bench for counter_ctrl
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort, periodic;
  logic [3:0] limit;
  logic [3:0] count;
  logic       tick, busy, done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  counter_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .abort   (abort),
    .periodic(periodic),
    .limit   (limit),
    .count   (count),
    .tick    (tick),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] c,
                         input logic tk);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tick"},  32'(tick),  32'(tk));
    check({tag, ".busy"},  32'(busy),  32'((st == S_RUN) || (st == S_PAUSE)));
    check({tag, ".done"},  32'(done),  32'(st == S_DONE));
  endtask

  task automatic go(input logic [3:0] lim, input logic per);
    limit = lim; periodic = per; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic kill();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  logic [3:0] per_cnt [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
  logic       per_tck [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b1; pause = 1'b0; abort = 1'b0; periodic = 1'b0; limit = 4'd0;
    cyc();
    chk_all("rst0", S_IDLE, 4'd0, 1'b0);
    cyc();
    chk_all("rst1", S_IDLE, 4'd0, 1'b0);
    rst = 1'b0; start = 1'b0;

    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk_all("idle_pause", S_IDLE, 4'd0, 1'b0);

    // one-shot, limit 3
    go(4'd3, 1'b0);
    chk_all("os_start", S_RUN, 4'd0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      cyc();
      chk_all($sformatf("os_c%0d", n), S_RUN, 4'(n), 1'b0);
    end
    cyc();
    chk_all("os_done", S_DONE, 4'd3, 1'b1);
    cyc();
    chk_all("os_hold", S_DONE, 4'd3, 1'b0);
    go(4'd3, 1'b0);
    chk_all("os_restart", S_RUN, 4'd0, 1'b0);
    kill();
    chk_all("os_abort", S_IDLE, 4'd0, 1'b0);

    // periodic, limit 2, limit change mid-run ignored
    go(4'd2, 1'b1);
    chk_all("per_start", S_RUN, 4'd0, 1'b0);
    limit = 4'd7;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_all($sformatf("per_%0d", i), S_RUN, per_cnt[i], per_tck[i]);
    end
    kill();

    // pause / resume, periodic, limit 5
    go(4'd5, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    chk_all("pr_c3", S_RUN, 4'd3, 1'b0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("pr_hold%0d", i), S_PAUSE, 4'd3, 1'b0);
      cyc();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("pr_resume", S_RUN, 4'd3, 1'b0);
    cyc();
    chk_all("pr_c4", S_RUN, 4'd4, 1'b0);
    cyc();
    chk_all("pr_c5", S_RUN, 4'd5, 1'b0);
    cyc();
    chk_all("pr_wrap", S_RUN, 4'd0, 1'b1);
    kill();

    // abort + start together in RUN
    go(4'd5, 1'b0);
    cyc();
    chk_all("as_c1", S_RUN, 4'd1, 1'b0);
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk_all("as_idle", S_IDLE, 4'd0, 1'b0);

    // pause on the wrap edge wins; wrap happens after resume
    go(4'd2, 1'b1);
    cyc();
    cyc();
    chk_all("pw_c2", S_RUN, 4'd2, 1'b0);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk_all("pw_pause", S_PAUSE, 4'd2, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("pw_resume", S_RUN, 4'd2, 1'b0);
    cyc();
    chk_all("pw_wrap", S_RUN, 4'd0, 1'b1);
    kill();

    // rst mid-run at count 7
    go(4'd9, 1'b0);
    for (int i = 0; i < 7; i++) cyc();
    chk_all("rr_c7", S_RUN, 4'd7, 1'b0);
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    chk_all("rr_reset", S_IDLE, 4'd0, 1'b0);

    // limit 0 periodic: tick every RUN cycle
    go(4'd0, 1'b1);
    chk_all("z_per_start", S_RUN, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all($sformatf("z_per_%0d", i), S_RUN, 4'd0, 1'b1);
    end
    kill();

    // limit 15 periodic: full-range wrap
    go(4'd15, 1'b1);
    for (int i = 0; i < 15; i++) cyc();
    chk_all("f_c15", S_RUN, 4'd15, 1'b0);
    cyc();
    chk_all("f_wrap", S_RUN, 4'd0, 1'b1);
    cyc();
    chk_all("f_c1", S_RUN, 4'd1, 1'b0);
    kill();

    // limit 0 one-shot
    go(4'd0, 1'b0);
    chk_all("z_os_start", S_RUN, 4'd0, 1'b0);
    cyc();
    chk_all("z_os_done", S_DONE, 4'd0, 1'b1);
    cyc();
    chk_all("z_os_hold", S_DONE, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
